// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, issues one fetch per cycle to a
// latency-1 instruction RAM and queues {inst, pc+4} for the IF/ID register.
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     CLK,
   input  logic                     CLR,
   input  logic                     flush,
   input  logic [31:0]              target_addr,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic                     mem_rvalid,
   input  logic [31:0]              mem_rdata,
   output logic                     out_valid,
   output logic [31:0]              out_inst,
   output logic [31:0]              out_pc4,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc4_q, inflight_pc4_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   pc4_q  [DEPTH];

   logic          issue;
   logic          push;
   logic          pop;
   logic [CW:0]   reserved;

   // A request is only issued when its response is guaranteed a free slot.
   assign reserved = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue    = !CLR && !flush && (reserved < {1'b0, DEPTH_C});
   assign push     = mem_rvalid && !flush && !CLR;
   assign pop      = out_valid && out_ready && !flush;

   assign mem_req   = issue;
   assign mem_addr  = fetch_pc_q;
   assign out_valid = (count_q != '0);
   assign out_inst  = out_valid ? inst_q[head_q] : 32'h0;
   assign out_pc4   = out_valid ? pc4_q[head_q]  : 32'h0;
   assign occupancy = count_q;

   always_comb begin
      fetch_pc_d     = fetch_pc_q;
      inflight_d     = issue;
      inflight_pc4_d = inflight_pc4_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      if (flush) begin
         fetch_pc_d = target_addr & 32'hFFFF_FFFC;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d     = fetch_pc_q + 32'd4;
            inflight_pc4_d = fetch_pc_q + 32'd4;
         end
         if (push) tail_d = tail_q + PW'(1);
         if (pop)  head_d = head_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Datapath storage carries no reset; validity is tracked by count/head/tail.
   always_ff @(posedge CLK) begin
      inflight_pc4_q <= inflight_pc4_d;
      if (push) begin
         inst_q[tail_q] <= mem_rdata;
         pc4_q[tail_q]  <= inflight_pc4_q;
      end
   end

   a_no_overflow: assert property (@(posedge CLK) disable iff (CLR)
      !(mem_rvalid && count_q == DEPTH_C));

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch buffer between the instruction RAM and the IF/ID pipeline register. It owns the fetch PC and issues one word-aligned fetch per cycle to a fixed-latency-1 instruction memory. Returned words are buffered with their PC+4 in a small FIFO, and the oldest is presented to IF/ID under a valid/ready handshake. A taken branch from the EX-stage condition handler flushes all buffered and in-flight fetches and redirects the fetch PC.

## Interface

Parameters:
- DEPTH, 4: FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- flush  in  1  taken branch (condition handler T_Addr); redirect this cycle.
- target_addr  in  32  branch target; bits [1:0] ignored (treated as 00).
- mem_req  out  1  fetch request to instruction RAM this cycle.
- mem_addr  out  32  fetch address; valid when mem_req=1.
- mem_rvalid  in  1  response valid; asserted exactly one cycle after each mem_req.
- mem_rdata  in  32  instruction word; valid with mem_rvalid.
- out_valid  out  1  head entry available to IF/ID.
- out_inst  out  32  head instruction; 0 when out_valid=0.
- out_pc4  out  32  head fetch address + 4; 0 when out_valid=0.
- out_ready  in  1  IF/ID load enable (hazard unit LE); pop when out_valid & out_ready.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

## Operation

- State: fetch_pc (32), FIFO storage DEPTH×64 {inst, pc4}, head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count, inflight (1 bit = mem_req registered), inflight_pc4 (32).
- Issue rule (combinational): mem_req = !CLR & !flush & (count + inflight < DEPTH). mem_addr = fetch_pc.
- On issue: fetch_pc <= fetch_pc + 4 (mod 2^32, wraps FFFF_FFFC→0000_0000); inflight <= 1; inflight_pc4 <= fetch_pc + 4. Otherwise inflight <= 0.
- Push: mem_rvalid & !flush → write {mem_rdata, inflight_pc4} at tail, tail++.
- Pop: out_valid & out_ready & !flush → head++.
- count update: +1 push only, −1 pop only, unchanged on simultaneous push+pop (also legal when count=DEPTH−1 or count=1).
- Full: reservation (count+inflight) guarantees push never occurs at count=DEPTH; mem_rvalid with count=DEPTH is a protocol error (assertion).
- Empty: out_valid=0; out_ready ignored; pop never underflows.
- Flush (priority over push, pop, issue): head<=0, tail<=0, count<=0, inflight<=0, fetch_pc <= {target_addr[31:2],2'b00}. Response returning in the flush cycle is dropped. No request issued in the flush cycle.
- CLR (priority over flush): fetch_pc<=RESET_PC, pointers/count/inflight<=0. Reset mid-operation discards everything identically to flush.

## Timing

- Reset values (cycle where CLR sampled high, and after): mem_req=0, out_valid=0, out_inst=0, out_pc4=0, occupancy=0.
- First fetch: cycle 0 (first cycle with CLR=0) mem_req=1, mem_addr=RESET_PC; rvalid in cycle 1; out_valid=1 in cycle 2 (2-cycle fetch-to-output latency).
- Throughput: one request and one push per cycle sustained when out_ready=1; count stays at 1.
- Stall: with out_ready=0, requests continue until count+inflight=DEPTH; mem_req drops the cycle that condition holds.
- Redirect: flush at cycle t → mem_req=1 at target in t+1, out_valid=1 in t+3. out_valid=0 in t+1 and t+2.
- out_* reflect registered head only; no combinational path mem_rdata→out_inst.

## Test plan

- Reset/stream: CLR 2 cycles, RAM word at addr n = n, out_ready=1 → mem_addr 0,4,8,… each cycle; out_valid from cycle 2; out_inst 0,4,8 with out_pc4 4,8,12 in order.
- Backpressure: out_ready=0 from reset → exactly 4 requests (addr 0..12), mem_req=0 thereafter, occupancy=4; raise out_ready → 4 pops in order, fetching resumes at 16.
- Simultaneous push/pop at DEPTH−1: occupancy=3, out_ready=1 with returning response → occupancy stays 3, order preserved.
- Flush: at mem_addr=20 assert flush, target_addr=0x103 → in-flight response dropped, occupancy=0, next mem_addr=0x100, first out_inst from 0x100 with out_pc4=0x104.
- Wrap: flush to 0xFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc4 of FFFF_FFFC entry = 0.
- Reset mid-stream: CLR with occupancy=3 → next cycle out_valid=0, occupancy=0; after release first mem_addr=RESET_PC.
